// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared constants for the lock controller and its button front end
//
// Contents:
//   CNT_W                      width of the debounce and hold counters
//   DEFAULT_DEBOUNCE_CYCLES    stable cycles needed to accept a level change
//   DEFAULT_LONG_PRESS_CYCLES  hold cycles before a long-press pulse
//   BTN_SET / BTN_ENTER        button channel indices used by the lock FSM
package lock_pkg;

  localparam int unsigned CNT_W = 16;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = 1000;
  localparam int unsigned DEFAULT_LONG_PRESS_CYCLES = 50000;

  localparam int unsigned BTN_SET   = 0;
  localparam int unsigned BTN_ENTER = 1;

endpackage : lock_pkg

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button channel: synchroniser, debounce, hold timer, pulses
//
// Ports:
//   clk              system clock
//   rst              synchronous active-high reset
//   btn_raw          asynchronous raw pin
//   btn_level        debounced state, 1 = pressed
//   press_pulse      one-cycle pulse when btn_level rises
//   release_pulse    one-cycle pulse when btn_level falls
//   long_press_pulse one-cycle pulse when a press has been held LONG_PRESS_CYCLES
module debounce_channel
  import lock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
  parameter bit          ACTIVE_LOW        = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse
);

  // Pin value that means "not pressed"; the synchroniser resets to it so
  // that leaving reset never looks like an edge.
  localparam logic RELEASED_PIN = (ACTIVE_LOW != 1'b0);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(LONG_PRESS_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             s;

  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    // Normalised "pressed" view of the synchronised pin.
    s          = sync2_q ^ RELEASED_PIN;

    level_d    = level_q;
    db_cnt_d   = '0;
    hold_cnt_d = hold_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;

    // Debounce: count consecutive cycles disagreeing with the accepted level.
    // Any agreeing cycle leaves db_cnt_d at its cleared default, so a bounce
    // back restarts qualification from zero.
    if (s != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d   = s;
        press_d   = s;
        release_d = ~s;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    // Hold timer runs off the accepted level and saturates, so the long-press
    // pulse is produced once per press, on the transition into saturation.
    if (!level_q) begin
      hold_cnt_d = '0;
    end else if (hold_cnt_q != HOLD_MAX) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
      long_d     = (hold_cnt_q == HOLD_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= RELEASED_PIN;
      sync2_q    <= RELEASED_PIN;
      level_q    <= 1'b0;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      level_q    <= level_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
    end
  end

  assign btn_level        = level_q;
  assign press_pulse      = press_q;
  assign release_pulse    = release_q;
  assign long_press_pulse = long_q;

endmodule : debounce_channel

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - multi-channel push-button synchroniser and debouncer
//
// Ports:
//   clk              system clock
//   rst              synchronous active-high reset
//   btn_raw          asynchronous raw pins, one per channel
//   btn_level        debounced state per channel, 1 = pressed
//   press_pulse      one-cycle pulse per channel on debounced press
//   release_pulse    one-cycle pulse per channel on debounced release
//   long_press_pulse one-cycle pulse per channel once a press is held long enough
module button_conditioner
  import lock_pkg::*;
#(
  parameter int unsigned NUM_BTN           = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
  parameter bit          ACTIVE_LOW        = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] long_press_pulse
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .ACTIVE_LOW       (ACTIVE_LOW)
    ) u_chan (
      .clk             (clk),
      .rst             (rst),
      .btn_raw         (btn_raw[i]),
      .btn_level       (btn_level[i]),
      .press_pulse     (press_pulse[i]),
      .release_pulse   (release_pulse[i]),
      .long_press_pulse(long_press_pulse[i])
    );
  end

endmodule : button_conditioner

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - self-checking bench for button_conditioner
module tb_button_conditioner;

  localparam int NB = 2;
  localparam int D  = 4;
  localparam int L  = 10;
  localparam int ME = 8192;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_raw = '1;
  logic [NB-1:0] btn_level, press_pulse, release_pulse, long_press_pulse;

  always #5 clk = ~clk;

  button_conditioner #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(btn_level), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .long_press_pulse(long_press_pulse)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state, indexed by absolute edge number.
  int            e_now    = 0;
  int            last_rst = 0;
  bit            rawp [NB][ME];
  bit            m_lvl [NB];
  int            last_chg [NB];
  int            press_edge [NB];
  logic [NB-1:0] x_level = '0, x_press = '0, x_rel = '0, x_long = '0;

  // Pressed value seen by the debounce logic at edge x: the pin sampled two
  // edges earlier, or "released" if that sample predates the last reset.
  function automatic bit s_at(int ch, int x);
    if (x - 2 <= last_rst) return 1'b0;
    return rawp[ch][x-2];
  endfunction

  always @(posedge clk) begin
    e_now = e_now + 1;
    if (e_now >= ME) begin
      $display("FAIL edge_budget edges=%0d limit=%0d", e_now, ME);
      $fatal(1, "edge budget exceeded");
    end
    if (rst) begin
      last_rst = e_now;
      for (int c = 0; c < NB; c++) begin
        m_lvl[c]      = 1'b0;
        last_chg[c]   = e_now;
        press_edge[c] = -100000;
      end
      x_level = '0; x_press = '0; x_rel = '0; x_long = '0;
    end else begin
      for (int c = 0; c < NB; c++) begin
        bit old, all;
        rawp[c][e_now] = ~btn_raw[c];
        old = m_lvl[c];
        x_press[c] = 1'b0;
        x_rel[c]   = 1'b0;
        // Long press: exactly L edges after the press edge, level still held.
        x_long[c] = old && (e_now - press_edge[c] == L);
        // Accept a change once D consecutive samples since the last change disagree.
        if (e_now - last_chg[c] >= D) begin
          all = 1'b1;
          for (int j = 0; j < D; j++)
            if (s_at(c, e_now - j) == old) all = 1'b0;
          if (all) begin
            m_lvl[c]    = ~old;
            last_chg[c] = e_now;
            x_press[c]  = ~old;
            x_rel[c]    = old;
            if (!old) press_edge[c] = e_now;
          end
        end
        x_level[c] = m_lvl[c];
      end
    end
  end

  task automatic chk(string nm, logic [NB-1:0] got, logic [NB-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%b exp=%b", nm, $time, got, exp);
    end
  endtask

  task automatic chkb(string nm, logic got, logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%b exp=%b", nm, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (e_now > 0) begin
      chk("model_level",   btn_level,        x_level);
      chk("model_press",   press_pulse,      x_press);
      chk("model_release", release_pulse,    x_rel);
      chk("model_long",    long_press_pulse, x_long);
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset with pins released, then idle.
    tick(2);
    chk("rst_level", btn_level, 2'b00);
    chk("rst_press", press_pulse, 2'b00);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("idle_level", btn_level, 2'b00);
      chk("idle_pulses", press_pulse | release_pulse | long_press_pulse, 2'b00);
    end

    // Clean press on channel 0.
    btn_raw[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chkb("press0_early", press_pulse[0], 1'b0);
    end
    tick(1);
    chkb("press0_on", press_pulse[0], 1'b1);
    chkb("press0_level", btn_level[0], 1'b1);
    tick(1);
    chkb("press0_width", press_pulse[0], 1'b0);
    chkb("press0_level_hold", btn_level[0], 1'b1);
    btn_raw[0] = 1'b1;
    tick(20);
    chkb("release0_level", btn_level[0], 1'b0);

    // Bounce, then settle pressed.
    for (int v = 0; v < 4; v++) begin
      btn_raw[0] = v[0];
      for (int i = 0; i < 2; i++) begin
        tick(1);
        chkb("bounce_quiet", press_pulse[0], 1'b0);
      end
    end
    btn_raw[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chkb("bounce_settle_early", press_pulse[0], 1'b0);
    end
    tick(1);
    chkb("bounce_settle_on", press_pulse[0], 1'b1);
    btn_raw[0] = 1'b1;
    tick(20);

    // Long press on channel 1, then release.
    btn_raw[1] = 1'b0;
    tick(5);
    tick(1);
    chkb("press1_on", press_pulse[1], 1'b1);
    for (int i = 0; i < 9; i++) begin
      tick(1);
      chkb("long1_early", long_press_pulse[1], 1'b0);
    end
    tick(1);
    chkb("long1_on", long_press_pulse[1], 1'b1);
    for (int i = 0; i < 15; i++) begin
      tick(1);
      chkb("long1_no_repeat", long_press_pulse[1], 1'b0);
    end
    btn_raw[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chkb("release1_early", release_pulse[1], 1'b0);
    end
    tick(1);
    chkb("release1_on", release_pulse[1], 1'b1);
    tick(20);

    // Simultaneous press.
    btn_raw = 2'b00;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("both_early", press_pulse, 2'b00);
    end
    tick(1);
    chk("both_on", press_pulse, 2'b11);
    btn_raw = 2'b11;
    tick(20);

    // Reset mid-hold, button held through it.
    btn_raw[0] = 1'b0;
    tick(6);
    chkb("rst_hold_press", press_pulse[0], 1'b1);
    tick(6);
    rst = 1'b1;
    tick(1);
    chk("rst_mid_level", btn_level, 2'b00);
    chk("rst_mid_pulses", press_pulse | release_pulse | long_press_pulse, 2'b00);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chkb("requal_early", press_pulse[0], 1'b0);
      chkb("requal_no_long", long_press_pulse[0], 1'b0);
    end
    tick(1);
    chkb("requal_on", press_pulse[0], 1'b1);
    btn_raw = 2'b11;
    tick(20);

    // Randomised pin activity with occasional resets.
    for (int seg = 0; seg < 400; seg++) begin
      for (int c = 0; c < NB; c++)
        if ($urandom_range(0, 1) == 1) btn_raw[c] = ~btn_raw[c];
      if ($urandom_range(0, 40) == 0) rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick($urandom_range(0, 14));
    end
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_button_conditioner
